// File: rtl/axil_uart_lite.sv
// AXI4-Lite UART (8N1, fixed baud) with TX/RX FIFOs, register-compatible with
// the UART Lite driver: RX FIFO 0x0, TX FIFO 0x4, STAT 0x8, CTRL 0xC.
module axil_uart_lite #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic        core_clk_i,
  input  logic        core_rst_i,
  input  logic [3:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        uart_int_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W        = PTR_W + 1;

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  localparam logic [1:0] A_RX   = 2'd0;
  localparam logic [1:0] A_TX   = 2'd1;
  localparam logic [1:0] A_STAT = 2'd2;
  localparam logic [1:0] A_CTRL = 2'd3;

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  // AXI handshake and register state
  logic        bvalid_q, rvalid_q;
  logic [31:0] rdata_q, rd_data_c;
  logic        intr_en_q, overrun_q, frame_q;
  logic        rx_ne_prev_q, tx_e_prev_q, int_q;
  logic        wr_acc_c, rd_acc_c, ctrl_wr_c, stat_rd_c;
  logic [7:0]  stat_c;

  // FIFO state
  logic [7:0]       tx_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wr_q, tx_rd_q;
  logic [LVL_W-1:0] tx_lvl_q;
  logic             tx_empty_c, tx_full_c, tx_push_c, tx_push_ok_c, tx_pop_c, tx_clr_c;
  logic [7:0]       tx_head_c;

  logic [7:0]       rx_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rx_wr_q, rx_rd_q;
  logic [LVL_W-1:0] rx_lvl_q;
  logic             rx_empty_c, rx_full_c, rx_push_c, rx_push_ok_c, rx_pop_c, rx_clr_c;
  logic [7:0]       rx_head_c;
  logic             overrun_set_c, frame_set_c;

  // TX shifter
  tx_state_e        tx_state_q, tx_state_d;
  logic [8:0]       tx_shift_q, tx_shift_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic             tx_line_q, tx_line_d, tx_load_c;

  // RX sampler
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_meta_q, rx_sync_q;

  logic unused_c;
  assign unused_c = ^{s_axi_wstrb, s_axi_wdata[31:8], s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign wr_acc_c      = s_axi_awvalid & s_axi_wvalid & ~bvalid_q;
  assign rd_acc_c      = s_axi_arvalid & ~rvalid_q;
  assign s_axi_awready = wr_acc_c;
  assign s_axi_wready  = wr_acc_c;
  assign s_axi_arready = ~rvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign uart_tx_o     = tx_line_q;
  assign uart_int_o    = int_q;

  assign tx_push_c = wr_acc_c & (s_axi_awaddr[3:2] == A_TX);
  assign ctrl_wr_c = wr_acc_c & (s_axi_awaddr[3:2] == A_CTRL);
  assign tx_clr_c  = ctrl_wr_c & s_axi_wdata[0];
  assign rx_clr_c  = ctrl_wr_c & s_axi_wdata[1];
  assign stat_rd_c = rd_acc_c & (s_axi_araddr[3:2] == A_STAT);
  assign rx_pop_c  = rd_acc_c & (s_axi_araddr[3:2] == A_RX) & ~rx_empty_c;

  assign tx_empty_c   = (tx_lvl_q == '0);
  assign tx_full_c    = (tx_lvl_q == LVL_FULL);
  assign tx_head_c    = tx_mem_q[tx_rd_q];
  assign tx_push_ok_c = tx_push_c & (~tx_full_c | tx_pop_c);

  assign rx_empty_c    = (rx_lvl_q == '0);
  assign rx_full_c     = (rx_lvl_q == LVL_FULL);
  assign rx_head_c     = rx_mem_q[rx_rd_q];
  assign rx_push_ok_c  = rx_push_c & (~rx_full_c | rx_pop_c);
  assign overrun_set_c = rx_push_c & rx_full_c & ~rx_pop_c;

  assign stat_c = {1'b0, frame_q, overrun_q, intr_en_q, tx_full_c, tx_empty_c, rx_full_c, ~rx_empty_c};

  always_comb begin : rd_mux
    rd_data_c = '0;
    case (s_axi_araddr[3:2])
      A_RX:    if (!rx_empty_c) rd_data_c = {24'd0, rx_head_c};
      A_STAT:  rd_data_c = {24'd0, stat_c};
      default: rd_data_c = '0;
    endcase
  end

  // Clearing a FIFO takes priority over any push/pop in the same cycle
  always_ff @(posedge core_clk_i) begin : tx_fifo_ptrs
    if (core_rst_i || tx_clr_c) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_lvl_q <= '0;
    end else begin
      if (tx_push_ok_c) tx_wr_q <= tx_wr_q + PTR_W'(1);
      if (tx_pop_c)     tx_rd_q <= tx_rd_q + PTR_W'(1);
      tx_lvl_q <= tx_lvl_q + LVL_W'(tx_push_ok_c) - LVL_W'(tx_pop_c);
    end
  end

  always_ff @(posedge core_clk_i) begin : tx_fifo_mem
    if (tx_push_ok_c) tx_mem_q[tx_wr_q] <= s_axi_wdata[7:0];
  end

  always_ff @(posedge core_clk_i) begin : rx_fifo_ptrs
    if (core_rst_i || rx_clr_c) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_lvl_q <= '0;
    end else begin
      if (rx_push_ok_c) rx_wr_q <= rx_wr_q + PTR_W'(1);
      if (rx_pop_c)     rx_rd_q <= rx_rd_q + PTR_W'(1);
      rx_lvl_q <= rx_lvl_q + LVL_W'(rx_push_ok_c) - LVL_W'(rx_pop_c);
    end
  end

  always_ff @(posedge core_clk_i) begin : rx_fifo_mem
    if (rx_push_ok_c) rx_mem_q[rx_wr_q] <= rx_byte_q;
  end

  always_ff @(posedge core_clk_i) begin : regs
    if (core_rst_i) begin
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      intr_en_q    <= 1'b0;
      overrun_q    <= 1'b0;
      frame_q      <= 1'b0;
      rx_ne_prev_q <= 1'b0;
      tx_e_prev_q  <= 1'b1;
      int_q        <= 1'b0;
    end else begin
      if (wr_acc_c)          bvalid_q <= 1'b1;
      else if (s_axi_bready) bvalid_q <= 1'b0;
      if (rd_acc_c) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data_c;
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
      if (ctrl_wr_c) intr_en_q <= s_axi_wdata[4];
      // A new error in the same cycle as a STAT read survives the clear
      overrun_q    <= overrun_set_c | (overrun_q & ~stat_rd_c);
      frame_q      <= frame_set_c | (frame_q & ~stat_rd_c);
      rx_ne_prev_q <= ~rx_empty_c;
      tx_e_prev_q  <= tx_empty_c;
      int_q        <= intr_en_q & ((~rx_empty_c & ~rx_ne_prev_q) | (tx_empty_c & ~tx_e_prev_q));
    end
  end

  always_ff @(posedge core_clk_i) begin : tx_state_reg
    if (core_rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '1;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // Bit 0 is the start bit, 1..8 data, 9 stop; a waiting byte loads as the stop bit ends
  always_comb begin : tx_next
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_cnt_d   = tx_cnt_q;
    tx_line_d  = tx_line_q;
    tx_load_c  = 1'b0;
    tx_pop_c   = 1'b0;
    case (tx_state_q)
      TX_IDLE: tx_load_c = ~tx_empty_c;
      TX_SEND: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_state_d = TX_IDLE;
            tx_load_c  = ~tx_empty_c;
          end else begin
            tx_line_d  = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[8:1]};
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_load_c && !tx_clr_c) begin
      tx_pop_c   = 1'b1;
      tx_state_d = TX_SEND;
      tx_shift_d = {1'b1, tx_head_c};
      tx_line_d  = 1'b0;
      tx_bit_d   = '0;
      tx_cnt_d   = '0;
    end
  end

  always_ff @(posedge core_clk_i) begin : rx_state_reg
    if (core_rst_i) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_byte_q  <= '0;
    end else begin
      rx_meta_q  <= uart_rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_byte_q  <= rx_byte_d;
    end
  end

  // Half-bit qualify of the start bit, then sample at bit centres
  always_comb begin : rx_next
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_byte_d   = rx_byte_q;
    rx_push_c   = 1'b0;
    frame_set_c = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d  = '0;
          rx_byte_d = {rx_sync_q, rx_byte_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_push_c  = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            frame_set_c = 1'b1;
            rx_state_d  = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_WAIT_HIGH: if (rx_sync_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axil_uart_lite.sv
// Scoreboard bench for axil_uart_lite: AXI register traffic, TX waveform,
// RX frames, overrun/frame errors, interrupt pulses and mid-frame reset.
module tb_axil_uart_lite;

  localparam int unsigned CPB = 10;

  logic        core_clk_i = 1'b0;
  logic        core_rst_i;
  logic [3:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [3:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        uart_rx_i;
  logic        uart_tx_o;
  logic        uart_int_o;

  int n_tests = 0;
  int n_fail  = 0;
  int int_cnt = 0;

  logic [31:0] rd_exp_q [$];
  logic [7:0]  tx_exp_q [$];
  logic [7:0]  rx_model [$];

  axil_uart_lite #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (16)
  ) dut (
    .core_clk_i   (core_clk_i),
    .core_rst_i   (core_rst_i),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .uart_rx_i    (uart_rx_i),
    .uart_tx_o    (uart_tx_o),
    .uart_int_o   (uart_int_o)
  );

  always #5 core_clk_i = ~core_clk_i;

  always @(posedge core_clk_i) if (uart_int_o === 1'b1) int_cnt <= int_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge core_clk_i);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data);
    bit got;
    s_axi_awaddr  = addr;
    s_axi_wdata   = data;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    #1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (s_axi_awready && s_axi_wready) got = 1'b1;
      @(posedge core_clk_i);
      #1;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    if (!got) check("aw_timeout", 32'd0, 32'd1);
    else      check("bvalid", 32'(s_axi_bvalid), 32'd1);
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    bit got;
    logic [31:0] e;
    rd_exp_q.push_back(exp);
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    #1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (s_axi_arready) got = 1'b1;
      @(posedge core_clk_i);
      #1;
    end
    s_axi_arvalid = 1'b0;
    e = rd_exp_q.pop_front();
    if (!got) begin
      check({tag, "_artimeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_rvalid"}, 32'(s_axi_rvalid), 32'd1);
    check(tag, s_axi_rdata, e);
  endtask

  task automatic rx_read(input string tag);
    logic [31:0] e;
    e = (rx_model.size() > 0) ? 32'(rx_model.pop_front()) : 32'd0;
    axi_read(4'h0, e, tag);
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    uart_rx_i = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      tick(CPB);
    end
    uart_rx_i = stop;
    tick(CPB);
    if (stop && rx_model.size() < 16) rx_model.push_back(b);
  endtask

  task automatic tx_capture(input string tag);
    logic [7:0] b;
    logic [7:0] e;
    int wt;
    wt = 0;
    while (uart_tx_o === 1'b1 && wt < 300) begin
      tick(1);
      wt++;
    end
    if (wt >= 300) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    tick(CPB / 2);
    check({tag, "_start"}, 32'(uart_tx_o), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick(CPB);
      b[i] = uart_tx_o;
    end
    tick(CPB);
    check({tag, "_stop"}, 32'(uart_tx_o), 32'd1);
    if (tx_exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 32'(b), 32'hFFFF_FFFF);
      return;
    end
    e = tx_exp_q.pop_front();
    check(tag, 32'(b), 32'(e));
  endtask

  initial begin
    logic [9:0] fr;
    int ok, c0, lows, wt;
    logic [7:0] b;

    core_rst_i    = 1'b1;
    s_axi_awaddr  = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = 4'hF;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b1;
    s_axi_araddr  = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    uart_rx_i     = 1'b1;
    tick(3);
    core_rst_i = 1'b0;
    tick(1);

    // Reset state
    check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    check("rst_rdata", s_axi_rdata, 32'd0);
    check("rst_tx", 32'(uart_tx_o), 32'd1);
    check("rst_int", 32'(uart_int_o), 32'd0);
    check("rst_arready", 32'(s_axi_arready), 32'd1);
    check("rst_awready", 32'(s_axi_awready), 32'd0);
    check("rst_resp", 32'({s_axi_bresp, s_axi_rresp}), 32'd0);
    axi_read(4'h8, 32'h04, "rst_stat");

    // TX 0x55 cycle-exact waveform
    axi_write(4'h4, 32'h55);
    check("tx_lat", 32'(uart_tx_o), 32'd1);
    tick(1);
    fr = {1'b1, 8'h55, 1'b0};
    for (int bi = 0; bi < 10; bi++) begin
      ok = 0;
      for (int c = 0; c < int'(CPB); c++) begin
        if (uart_tx_o === fr[bi]) ok++;
        tick(1);
      end
      check($sformatf("tx55_bit%0d", bi), 32'(ok), 32'(CPB));
    end
    check("tx_idle_after", 32'(uart_tx_o), 32'd1);
    axi_read(4'h8, 32'h04, "tx_stat");

    // RX single frame
    uart_send(8'hA3, 1'b1);
    tick(3);
    axi_read(4'h8, 32'h05, "rx1_stat");
    rx_read("rx1_data");
    axi_read(4'h8, 32'h04, "rx1_stat_after");
    axi_read(4'h4, 32'h0, "rd_tx_addr");

    // Frame error, line held low
    uart_send(8'h77, 1'b0);
    tick(30);
    axi_read(4'h8, 32'h44, "ferr_stat");
    tick(100);
    axi_read(4'h8, 32'h04, "ferr_low_hold");
    uart_rx_i = 1'b1;
    tick(20);
    uart_send(8'h5A, 1'b1);
    tick(3);
    axi_read(4'h8, 32'h05, "ferr_recover_stat");
    rx_read("ferr_recover_data");

    // 17 frames: overrun on the last
    for (int i = 1; i <= 17; i++) begin
      b = 8'(i * 37 + 5);
      uart_send(b, 1'b1);
    end
    tick(3);
    axi_read(4'h8, 32'h27, "ovr_stat");
    axi_read(4'h8, 32'h07, "ovr_stat_clr");
    for (int i = 0; i < 16; i++) rx_read($sformatf("ovr_data%0d", i));
    axi_read(4'h8, 32'h04, "ovr_drained");
    rx_read("rx_empty_read");

    // Interrupts
    c0 = int_cnt;
    axi_write(4'hC, 32'h10);
    tick(3);
    check("int_none_on_enable", 32'(int_cnt), 32'(c0));
    axi_read(4'hC, 32'h0, "rd_ctrl_addr");
    axi_read(4'h8, 32'h14, "int_stat");
    tx_exp_q.push_back(8'h41);
    axi_write(4'h4, 32'h41);
    tx_capture("int_tx");
    check("int_tx_pulse", 32'(int_cnt), 32'(c0 + 1));
    uart_send(8'h3C, 1'b1);
    tick(3);
    check("int_rx_pulse", 32'(int_cnt), 32'(c0 + 2));
    rx_read("int_rx_data");
    tick(3);
    check("int_no_pulse_on_pop", 32'(int_cnt), 32'(c0 + 2));

    // Reset during the 4th data bit with B and R held pending
    s_axi_bready = 1'b0;
    s_axi_rready = 1'b0;
    axi_write(4'h4, 32'hF0);
    wt = 0;
    while (uart_tx_o === 1'b1 && wt < 50) begin
      tick(1);
      wt++;
    end
    check("mr_tx_started", 32'(wt < 50), 32'd1);
    tick(44);
    check("mr_tx_mid", 32'(uart_tx_o), 32'd0);
    s_axi_araddr  = 4'h8;
    s_axi_arvalid = 1'b1;
    tick(1);
    s_axi_arvalid = 1'b0;
    tick(2);
    check("mr_rvalid_hold", 32'(s_axi_rvalid), 32'd1);
    check("mr_bvalid_hold", 32'(s_axi_bvalid), 32'd1);
    core_rst_i = 1'b1;
    tick(1);
    check("mr_tx", 32'(uart_tx_o), 32'd1);
    check("mr_bvalid", 32'(s_axi_bvalid), 32'd0);
    check("mr_rvalid", 32'(s_axi_rvalid), 32'd0);
    check("mr_rdata", s_axi_rdata, 32'd0);
    core_rst_i   = 1'b0;
    s_axi_bready = 1'b1;
    s_axi_rready = 1'b1;
    tick(1);
    axi_read(4'h8, 32'h04, "mr_stat");
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      if (uart_tx_o !== 1'b1) lows++;
      tick(1);
    end
    check("mr_tx_quiet", 32'(lows), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
